// File: rtl/resp_server.sv
// resp_server: CH-channel round-robin request target; responses appear LAT cycles after accept via a DEPTH-entry FIFO.
// Define RESP_SERVER_SEQ_DATA_EN to return RDATA plus a per-accept sequence number instead of constant RDATA.
module resp_server #(
    parameter int             DW    = 4,
    parameter int             CH    = 2,
    parameter int             LAT   = 2,
    parameter int             DEPTH = 4,
    parameter logic [DW-1:0]  RDATA = 4'h5,
    localparam int            CW    = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [CH-1:0] req_valid,
    output logic [CH-1:0] req_ready,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic [CW-1:0] rsp_ch
);

    localparam int OW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [OW-1:0] outstanding;
    logic [CW-1:0] rr_ptr;
    logic [CW-1:0] rr_next;
    logic [CW-1:0] grant_idx;
    logic          grant_any;
    logic          credit;
    logic          accept;
    logic          rsp_fire;
    logic [DW-1:0] acc_data;
    logic [CW:0]   scan_sum;
    logic [CW-1:0] scan_idx;

    logic          push_v;
    logic [CW-1:0] push_ch;
    logic [DW-1:0] push_data;

    logic [CW-1:0] fifo_ch   [DEPTH];
    logic [DW-1:0] fifo_data [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [OW-1:0] fifo_count;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit comes only from the registered count, so a same-cycle response never frees a slot early.
    assign credit   = outstanding < OW'(DEPTH);
    assign rsp_fire = rsp_valid & rsp_ready;
    assign accept   = grant_any & credit & ~reset;
    assign rr_next  = (grant_idx == CW'(CH - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = 0; k < CH; k++) begin
            scan_sum = {1'b0, rr_ptr} + (CW+1)'(k);
            if (scan_sum >= (CW+1)'(CH)) begin
                scan_sum = scan_sum - (CW+1)'(CH);
            end
            scan_idx = scan_sum[CW-1:0];
            if (!grant_any && req_valid[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outstanding <= '0;
            rr_ptr      <= '0;
        end else begin
            if (accept && !rsp_fire) begin
                outstanding <= outstanding + 1'b1;
            end else if (!accept && rsp_fire) begin
                outstanding <= outstanding - 1'b1;
            end
            if (accept) begin
                rr_ptr <= rr_next;
            end
        end
    end

`ifdef RESP_SERVER_SEQ_DATA_EN
    logic [DW-1:0] seq_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seq_cnt <= '0;
        end else if (accept) begin
            seq_cnt <= seq_cnt + 1'b1;
        end
    end

    assign acc_data = RDATA + seq_cnt;
`else
    assign acc_data = RDATA;
`endif

    // The FIFO write itself is the last latency stage, so only LAT-1 registers sit in front of it.
    generate
        if (LAT == 1) begin : g_direct
            assign push_v    = accept;
            assign push_ch   = grant_idx;
            assign push_data = acc_data;
        end else begin : g_pipe
            localparam int PS = LAT - 1;
            logic          pv [PS];
            logic [CW-1:0] pc [PS];
            logic [DW-1:0] pd [PS];

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    for (int s = 0; s < PS; s++) begin
                        pv[s] <= 1'b0;
                    end
                end else begin
                    pv[0] <= accept;
                    for (int s = 1; s < PS; s++) begin
                        pv[s] <= pv[s-1];
                    end
                end
            end

            always_ff @(posedge clock) begin
                pc[0] <= grant_idx;
                pd[0] <= acc_data;
                for (int s = 1; s < PS; s++) begin
                    pc[s] <= pc[s-1];
                    pd[s] <= pd[s-1];
                end
            end

            assign push_v    = pv[PS-1];
            assign push_ch   = pc[PS-1];
            assign push_data = pd[PS-1];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (push_v) begin
            fifo_ch[wr_ptr]   <= push_ch;
            fifo_data[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_v) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rsp_fire) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push_v && !rsp_fire) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (!push_v && rsp_fire) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

    assign rsp_valid = (fifo_count != '0);
    assign rsp_data  = rsp_valid ? fifo_data[rd_ptr] : '0;
    assign rsp_ch    = rsp_valid ? fifo_ch[rd_ptr] : '0;

endmodule

// File: tb/tb_resp_server.sv
// tb_resp_server: directed and random stimulus for resp_server, checked cycle by cycle
// against a queue-based model of accepts, credits and in-order responses.
module tb_resp_server;

    localparam int         DW    = 4;
    localparam int         CH    = 2;
    localparam int         LAT   = 2;
    localparam int         DEPTH = 4;
    localparam logic [3:0] RDATA = 4'h5;

    logic          clock = 1'b0;
    logic          reset;
    logic [CH-1:0] req_valid;
    logic [CH-1:0] req_ready;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [0:0]    rsp_ch;

    always #5 clock = ~clock;

    resp_server #(
        .DW(DW), .CH(CH), .LAT(LAT), .DEPTH(DEPTH), .RDATA(RDATA)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_ch(rsp_ch)
    );

    typedef struct {
        int            ch;
        logic [DW-1:0] data;
        int            vis;
    } rsp_t;

    rsp_t pending[$];
    int   m_outstanding = 0;
    int   m_rr = 0;
    int   m_seq = 0;
    int   now = 0;
    int   checks = 0;
    int   passed = 0;
    int   failed = 0;
    int   accept_cnt = 0;

    task automatic applyStimulus(input logic [CH-1:0] rv, input logic rr);
        req_valid = rv;
        rsp_ready = rr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) begin
            passed++;
        end else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h at cycle %0d", tag, observed, expected, now);
        end
    endtask

    // One clock cycle: drive, predict from the model, compare, then advance the model.
    task automatic step(input logic [CH-1:0] rv, input logic rr);
        logic [CH-1:0] exp_ready;
        logic          exp_rv;
        logic [DW-1:0] exp_data;
        logic [DW-1:0] new_data;
        int            exp_ch;
        int            g;
        int            idx;
        @(negedge clock);
        applyStimulus(rv, rr);
        #1;
        exp_ready = '0;
        g = -1;
        if (m_outstanding < DEPTH) begin
            for (int k = 0; k < CH; k++) begin
                idx = (m_rr + k) % CH;
                if (g < 0 && rv[idx] == 1'b1) g = idx;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        exp_rv   = (pending.size() > 0) && (pending[0].vis <= now);
        exp_data = exp_rv ? pending[0].data : '0;
        exp_ch   = exp_rv ? pending[0].ch : 0;
        checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
        checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        checkOutput("rsp_data", 32'(rsp_data), 32'(exp_data));
        checkOutput("rsp_ch", 32'(rsp_ch), 32'(exp_ch));
        if (req_ready != '0) accept_cnt++;
        if (exp_rv && rr) begin
            void'(pending.pop_front());
            m_outstanding--;
        end
        if (g >= 0) begin
`ifdef RESP_SERVER_SEQ_DATA_EN
            new_data = RDATA + DW'(m_seq);
`else
            new_data = RDATA;
`endif
            pending.push_back('{ch: g, data: new_data, vis: now + LAT});
            m_outstanding++;
            m_rr = (g + 1) % CH;
            m_seq++;
        end
        now++;
    endtask

    // Hold reset with requests pending and confirm every output stays quiet.
    task automatic doReset(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clock);
            reset = 1'b1;
            applyStimulus('1, 1'b1);
            #1;
            checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
            checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
            checkOutput("rst_rsp_ch", 32'(rsp_ch), 32'd0);
            now++;
        end
        pending.delete();
        m_outstanding = 0;
        m_rr = 0;
        m_seq = 0;
        @(negedge clock);
        applyStimulus('0, 1'b1);
        reset = 1'b0;
        now++;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus('0, 1'b0);
        $display("[TB] reset");
        doReset(2);

        $display("[TB] single request");
        step(2'b01, 1'b1);
        repeat (4) step(2'b00, 1'b1);

        $display("[TB] round-robin");
        repeat (8) step(2'b11, 1'b1);
        repeat (6) step(2'b00, 1'b1);

        $display("[TB] back-pressure");
        accept_cnt = 0;
        repeat (8) step(2'b01, 1'b0);
        checkOutput("bp_accepts", 32'(accept_cnt), 32'd4);
        repeat (8) step(2'b01, 1'b1);
        repeat (6) step(2'b00, 1'b1);

        $display("[TB] sequence data");
        doReset(1);
        repeat (18) step(2'b01, 1'b1);
        repeat (6) step(2'b00, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            step(CH'($urandom), $urandom_range(0, 3) != 0);
        end
        repeat (10) step(2'b00, 1'b1);

        $display("[TB] reset mid-flight");
        repeat (3) step(2'b01, 1'b0);
        doReset(2);
        repeat (6) step(2'b00, 1'b1);
        step(2'b01, 1'b1);
        repeat (4) step(2'b00, 1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
